mux_rr_sched: RTL
=================

// Module: mux_rr_sched
// PURPOSE
//   Round-robin scheduler that shares one N:1 mux output path among N requesters.
//   Arbitrates requests, drives the registered mux select and one-hot grant, and moves
//   one beat per grant across a valid/ready handshake to the downstream consumer.
//   Sits in front of the mux tree and supplies its select lines; the mux itself is datapath.
// PARAMETERS
//   N        8  number of requesters; power of 2, 2..16
//   W        1  data width per requester, in bits
//   MAX_HOLD 4  max consecutive beats per grant; used only with MUX_ARB_HOLD_EN; >=1
// PORTS
//   clk       in   1            rising-edge clock
//   rst_n     in   1            asynchronous active-low reset
//   req       in   N            request per requester; hold high until matching ack
//   din       in   N*W          requester data, slice i = din[i*W +: W]
//   gnt       out  N            one-hot grant, registered; all zeros when idle
//   sel       out  $clog2(N)    registered mux select = index of gnt bit
//   ack       out  N            one-cycle pulse on the grantee's bit when its beat transfers
//   out_valid out  1            output beat valid
//   out_data  out  W            din slice selected by sel
//   out_ready in   1            downstream accepts beat when high together with out_valid
//   busy      out  1            high in XFER state
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, gnt=0, sel=0, ack=0, out_valid=0, ptr=N-1, hold_cnt=0.
//   - ptr holds the last granted index. Search order is ptr+1, ptr+2, ... mod N (wrap N-1->0).
//   - IDLE: if |req, register winner w -> gnt=1<<w, sel=w, ptr=w; go XFER. Else stay.
//     Latency from req rising to out_valid is 1 cycle.
//   - XFER: out_valid=1; out_data=din[sel] combinational from registered sel.
//     - out_valid&&out_ready: ack[sel] pulses in the same cycle (combinational from the handshake).
//       Re-arbitrate on the same edge, excluding the current grantee unless it is the only
//       requester. Back-to-back beats have no idle cycle.
//       If no other request exists and the grantee still requests, it is re-granted.
//       If no request remains, go IDLE.
//     - Grantee drops req before handshake (abort): out_valid and gnt go low next cycle,
//       no ack, ptr keeps w, go IDLE.
//     - out_ready=0: hold gnt, sel and out_valid stable indefinitely. No timeout.
//   - New req arriving while another requester is in XFER is only considered at the next
//     arbitration edge.
//   - All req=0 in IDLE: outputs stay at reset values.
//   - Reset asserted mid-XFER: beat is dropped with no ack; outputs go to reset values immediately.
//   - At most one gnt bit is set at any time; ack is a subset of gnt.
// CONFIGURATION
//   - MUX_ARB_HOLD_EN defined: on a handshake, if the grantee still requests and
//     hold_cnt < MAX_HOLD-1, keep the grant (hold_cnt++, ptr unchanged). Otherwise release,
//     reset hold_cnt to 0 and arbitrate as above. The burst length per grant is at most MAX_HOLD.
//   - MUX_ARB_HOLD_EN undefined: hold_cnt is not built; the grant always rotates after each
//     beat, and MAX_HOLD is ignored.
// STRUCTURE
//   - Package mux_arb_pkg: state encoding (ST_IDLE=1'b0, ST_XFER=1'b1), function
//     clog2_n, and default parameter constants.
//   - Sub-module rr_pick #(N): combinational rotating-priority finder.
//     Inputs req and ptr; outputs valid and index. Implemented as double-width mask,
//     then priority encode, then mod N. Instantiated once.
//   - Top level holds the FSM, ptr, hold_cnt and the sel-driven output mux.
// TESTING
//   1 Reset: rst_n=0 with req=8'hFF -> gnt=0, sel=0, out_valid=0, ack=0 throughout.
//   2 Rotation: req=8'hFF held, out_ready=1 -> sel sequence 0,1,2,...,7,0; one ack per cycle;
//     no idle cycles between beats.
//   3 Backpressure: req=8'h10, out_ready=0 for 5 cycles -> sel=4 and out_data=din[4] stable;
//     out_ready=1 -> ack=8'h10 in that cycle.
//   4 Abort: req=8'h04 granted, then req drops before out_ready -> next cycle out_valid=0,
//     gnt=0, no ack; state IDLE.
//   5 Wrap/fairness: ptr=7, req=8'h81 -> grant 0, then 7, then 0.
//     Single req=8'h02 held -> re-granted every beat.
//   6 MUX_ARB_HOLD_EN, MAX_HOLD=4: req=8'h03, out_ready=1 -> sel=0 for 4 beats, then 1 for
//     4 beats; without the macro sel alternates 0,1,0,1.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux scheduler.
// Build option: MUX_ARB_HOLD_EN (multi-beat grant hold), consumed by mux_rr_sched.
package mux_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  localparam int unsigned N_DEF        = 8;
  localparam int unsigned W_DEF        = 1;
  localparam int unsigned MAX_HOLD_DEF = 4;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int unsigned clog2_n(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_rr_sched_rr_pick.sv
// Combinational rotating-priority finder: first set req bit after ptr, wrapping mod N.
// Double-width copy of req is masked to the window (ptr, ptr+N], then priority encoded.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  localparam int unsigned PW = clog2_n(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] index
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;

  always_comb begin
    dbl    = {req, req};
    masked = '0;
    for (int i = 0; i < 2 * N; i++) begin
      masked[i] = dbl[i] && (i > int'(ptr)) && (i <= int'(ptr) + int'(N));
    end
  end

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!valid && masked[i]) begin
        valid = 1'b1;
        index = PW'(i % int'(N));
      end
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler driving the select of an N:1 mux and a valid/ready output beat.
// Build option: define MUX_ARB_HOLD_EN to let a grantee keep the grant for up to MAX_HOLD beats.
module mux_rr_sched
  import mux_arb_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned W        = W_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  localparam int unsigned SW = clog2_n(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] din,
  output logic [N-1:0]   gnt,
  output logic [SW-1:0]  sel,
  output logic [N-1:0]   ack,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  input  logic           out_ready,
  output logic           busy
);

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          pick_valid;
  logic [SW-1:0] pick_idx;
  logic          hs;
  logic          keep;

  // Searching from ptr_q = current grantee visits every other requester first and the
  // grantee itself last, so the same picker serves IDLE and the post-beat rotation.
  rr_pick #(
    .N(N)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .valid(pick_valid),
    .index(pick_idx)
  );

  assign hs = out_valid && out_ready;

`ifdef MUX_ARB_HOLD_EN
  localparam int unsigned HW = clog2_n(MAX_HOLD);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    keep       = 1'b0;
    hold_cnt_d = hold_cnt_q;
    if (state_q == ST_XFER) begin
      if (hs) begin
        if (req[sel_q] && (hold_cnt_q < HW'(MAX_HOLD - 1))) begin
          keep       = 1'b1;
          hold_cnt_d = hold_cnt_q + HW'(1);
        end else begin
          hold_cnt_d = '0;
        end
      end else if (!req[sel_q]) begin
        hold_cnt_d = '0;
      end
    end else begin
      hold_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
  assign keep = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d         = ST_XFER;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          sel_d           = pick_idx;
          ptr_d           = pick_idx;
        end
      end
      ST_XFER: begin
        if (hs) begin
          if (!keep) begin
            if (pick_valid) begin
              gnt_d           = '0;
              gnt_d[pick_idx] = 1'b1;
              sel_d           = pick_idx;
              ptr_d           = pick_idx;
            end else begin
              state_d = ST_IDLE;
              gnt_d   = '0;
              sel_d   = '0;
            end
          end
        end else if (!req[sel_q]) begin
          // Abort: grantee withdrew before its beat moved; ptr keeps its index.
          state_d = ST_IDLE;
          gnt_d   = '0;
          sel_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= SW'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out_valid = (state_q == ST_XFER);
  assign busy      = (state_q == ST_XFER);
  assign ack       = hs ? gnt_q : '0;
  assign out_data  = din[int'(sel_q) * W +: W];

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_ack_subset : assert property (@(posedge clk) disable iff (!rst_n) (ack & ~gnt) == '0);
  a_sel_match  : assert property (@(posedge clk) disable iff (!rst_n) out_valid |-> gnt[sel]);
  a_bp_stable  : assert property (@(posedge clk) disable iff (!rst_n)
                                  (out_valid && !out_ready && req[sel])
                                  |=> (out_valid && $stable(sel) && $stable(gnt)));

endmodule
